// File: rtl/imm_encoder_pkg.sv
// Shared core definitions: immediate formats, range limits and the
// output-buffer entry layout used by the immediate encoder.
package imm_encoder_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_fmt_t;

    localparam int I_MIN = -2048;
    localparam int I_MAX = 2047;
    localparam int B_MIN = -4096;
    localparam int B_MAX = 4094;
    localparam int J_MIN = -1048576;
    localparam int J_MAX = 1048574;

    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [24:0] instr;
        logic [2:0]  fmt;
        logic        err;
    } enc_entry_t;

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational packer: places immediate and register fields into
// instruction bits [31:7] and flags immediates the format cannot hold.
module imm_pack
    import imm_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            fmt_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [2:0]            funct3_i,
    output logic [24:0]           instr_o,
    output logic                  err_o
);

    localparam logic signed [DATA_WIDTH-1:0] LO_I = DATA_WIDTH'(I_MIN);
    localparam logic signed [DATA_WIDTH-1:0] HI_I = DATA_WIDTH'(I_MAX);
    localparam logic signed [DATA_WIDTH-1:0] LO_B = DATA_WIDTH'(B_MIN);
    localparam logic signed [DATA_WIDTH-1:0] HI_B = DATA_WIDTH'(B_MAX);
    localparam logic signed [DATA_WIDTH-1:0] LO_J = DATA_WIDTH'(J_MIN);
    localparam logic signed [DATA_WIDTH-1:0] HI_J = DATA_WIDTH'(J_MAX);

    logic signed [DATA_WIDTH-1:0] simm;
    logic [31:0] v;
    logic i_ok;
    logic b_ok;
    logic u_ok;
    logic j_ok;

    assign simm = $signed(imm_i);
    assign v    = imm_i[31:0];

    assign i_ok = (simm >= LO_I) && (simm <= HI_I);
    assign b_ok = (simm >= LO_B) && (simm <= HI_B) && !v[0];
    assign u_ok = (v[11:0] == 12'd0);
    assign j_ok = (simm >= LO_J) && (simm <= HI_J) && !v[0];

    // Out-of-range values are still packed (truncated), only flagged.
    always_comb begin
        instr_o = '0;
        err_o   = 1'b0;
        unique case (fmt_i)
            IMM_I: begin
                instr_o = {v[11:0], rs1_i, funct3_i, rd_i};
                err_o   = !i_ok;
            end
            IMM_S: begin
                instr_o = {v[11:5], rs2_i, rs1_i, funct3_i, v[4:0]};
                err_o   = !i_ok;
            end
            IMM_B: begin
                instr_o = {v[12], v[10:5], rs2_i, rs1_i,
                           funct3_i, v[4:1], v[11]};
                err_o   = !b_ok;
            end
            IMM_U: begin
                instr_o = {v[31:12], rd_i};
                err_o   = !u_ok;
            end
            IMM_J: begin
                instr_o = {v[20], v[10:1], v[11], v[19:12], rd_i};
                err_o   = !j_ok;
            end
            default: begin
                instr_o = '0;
                err_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: packs a request into a 2-entry output FIFO and
// keeps saturating counts of popped words and popped error words.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_fmt,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [24:0]           out_instruction,
    output logic [2:0]            out_fmt,
    output logic                  out_err,
    output logic [15:0]           enc_count,
    output logic [7:0]            err_count
);

    enc_entry_t  mem_q [FIFO_DEPTH];
    enc_entry_t  wr_entry;
    enc_entry_t  head;
    logic [1:0]  occ_q, occ_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [15:0] enc_cnt_q, enc_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [24:0] pk_instr;
    logic        pk_err;
    logic        push;
    logic        pop;

    imm_pack #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_pack (
        .fmt_i    (in_fmt),
        .imm_i    (in_imm),
        .rd_i     (in_rd),
        .rs1_i    (in_rs1),
        .rs2_i    (in_rs2),
        .funct3_i (in_funct3),
        .instr_o  (pk_instr),
        .err_o    (pk_err)
    );

    assign wr_entry = '{instr: pk_instr, fmt: in_fmt, err: pk_err};
    assign head     = mem_q[rd_q];

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (occ_q < 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_instruction = head.instr;
    assign out_fmt         = head.fmt;
    assign out_err         = head.err;
    assign enc_count       = enc_cnt_q;
    assign err_count       = err_cnt_q;

    always_comb begin
        occ_d     = occ_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        enc_cnt_d = enc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wr_d = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
            if (enc_cnt_q != 16'hFFFF) begin
                enc_cnt_d = enc_cnt_q + 16'd1;
            end
            if (head.err && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q     <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            enc_cnt_q <= '0;
            err_cnt_q <= '0;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
        end else begin
            occ_q     <= occ_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            enc_cnt_q <= enc_cnt_d;
            err_cnt_q <= err_cnt_d;
            if (push) begin
                mem_q[wr_q] <= wr_entry;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized and directed bench for imm_encoder against a queue-based
// reference model with an instruction-level immediate decoder.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_instruction;
    logic [2:0]  out_fmt;
    logic        out_err;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    imm_encoder #(.DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_fmt          (in_fmt),
        .in_imm          (in_imm),
        .in_rd           (in_rd),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_funct3       (in_funct3),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_fmt         (out_fmt),
        .out_err         (out_err),
        .enc_count       (enc_count),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] w;
        logic [2:0]  fmt;
        logic        err;
        logic        rt;
        logic [31:0] imm;
    } exp_t;

    exp_t  q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    m_enc = 0;
    int    m_err = 0;
    bit    mon_on = 0;
    bit    just_rst = 0;
    bit    rand_rdy = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference encoder: bit placement and range rules on plain integers.
    function automatic logic [25:0] ref_enc(logic [2:0] f, logic [31:0] imm,
                                            logic [4:0] rd, logic [4:0] rs1,
                                            logic [4:0] rs2, logic [2:0] f3);
        int          v = $signed(imm);
        logic [24:0] w = '0;
        logic        e = 1'b1;
        case (f)
            3'd0: begin
                w = {imm[11:0], rs1, f3, rd};
                e = (v < -2048) || (v > 2047);
            end
            3'd1: begin
                w = {imm[11:5], rs2, rs1, f3, imm[4:0]};
                e = (v < -2048) || (v > 2047);
            end
            3'd2: begin
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]};
                e = (v < -4096) || (v > 4094) || (v % 2 != 0);
            end
            3'd3: begin
                w = {imm[31:12], rd};
                e = (imm % 4096) != 0;
            end
            3'd4: begin
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd};
                e = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
            end
            default: begin
                w = '0;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    // Decoder view: rebuild the full instruction and extract as a core would.
    function automatic logic [31:0] sx_decode(logic [2:0] f, logic [24:0] w);
        logic [31:0] ins = {w, 7'b0};
        case (f)
            3'd0: return {{20{ins[31]}}, ins[31:20]};
            3'd1: return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2: return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3: return {ins[31:12], 12'b0};
            3'd4: return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, q.size() < 2);
            chk("enc_count", enc_count, m_enc);
            chk("err_count", err_count, m_err);
            if (q.size() != 0) begin
                chk("head_instr", out_instruction, q[0].w);
                chk("head_fmt", out_fmt, q[0].fmt);
                chk("head_err", out_err, q[0].err);
            end else if (just_rst) begin
                chk("rst_instr", out_instruction, 0);
                chk("rst_fmt", out_fmt, 0);
                chk("rst_err", out_err, 0);
            end
        end
        if (rst) begin
            q.delete();
            m_enc    = 0;
            m_err    = 0;
            just_rst = 1;
            mon_on   = 1;
        end else if (mon_on) begin
            bit can_push;
            can_push = q.size() < 2;
            if (q.size() != 0 && out_ready) begin
                exp_t h;
                h = q.pop_front();
                if (h.rt) chk("roundtrip", sx_decode(h.fmt, h.w), h.imm);
                if (m_enc < 65535) m_enc++;
                if (h.err && m_err < 255) m_err++;
            end
            if (in_valid && can_push) begin
                exp_t n;
                logic [25:0] r;
                r     = ref_enc(in_fmt, in_imm, in_rd, in_rs1, in_rs2, in_funct3);
                n.w   = r[24:0];
                n.err = r[25];
                n.fmt = in_fmt;
                n.imm = in_imm;
                n.rt  = !r[25] && (in_fmt < 3'd5);
                q.push_back(n);
                just_rst = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(logic [2:0] f, logic [31:0] imm, logic [4:0] rd,
                        logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3);
        int t = 0;
        bit acc;
        in_valid  = 1'b1;
        in_fmt    = f;
        in_imm    = imm;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        forever begin
            @(negedge clk);
            acc = in_ready && !rst;
            tick();
            if (acc) break;
            t++;
            if (t > 50) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", t < 20, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset(int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm(logic [2:0] f);
        int v;
        if ($urandom_range(0, 3) == 0) return $urandom;
        case (f)
            3'd0, 3'd1: v = int'($urandom_range(0, 4095)) - 2048;
            3'd2: v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            3'd3: v = int'({$urandom_range(0, 32'hFFFFF), 12'b0});
            3'd4: v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
            default: v = int'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_fmt    = 3'd0;
        in_imm    = 32'd7;
        in_rd     = 5'd1;
        in_rs1    = 5'd2;
        in_rs2    = 5'd3;
        in_funct3 = 3'd0;
        out_ready = 1'b0;
        do_reset(3);
        in_valid = 1'b0;
        tick();
        chk("rst_valid", out_valid, 0);

        send(3'd0, 32'hFFFF_FFFF, 5'd5, 5'd3, 5'd0, 3'd2);
        chk("i_imm", out_instruction[24:13], 12'hFFF);
        chk("i_rs1", out_instruction[12:8], 3);
        chk("i_f3", out_instruction[7:5], 2);
        chk("i_rd", out_instruction[4:0], 5);
        chk("i_err", out_err, 0);
        chk("lw_sext", sx_decode(out_fmt, out_instruction), 32'hFFFF_FFFF);
        drain();

        send(3'd2, -32'sd4096, 5'd0, 5'd9, 5'd10, 3'd1);
        chk("b_bit24", out_instruction[24], 1);
        chk("b_hi", out_instruction[23:18], 0);
        chk("b_lo", out_instruction[4:1], 0);
        chk("b_b0", out_instruction[0], 0);
        chk("b_err", out_err, 0);
        drain();
        send(3'd2, 32'd3, 5'd0, 5'd1, 5'd2, 3'd0);
        chk("b3_err", out_err, 1);
        drain();
        chk("b3_errcnt", err_count, 1);

        send(3'd3, 32'h1234_5000, 5'd7, 5'd0, 5'd0, 3'd0);
        chk("u_hi", out_instruction[24:5], 20'h12345);
        chk("u_err", out_err, 0);
        drain();
        send(3'd3, 32'h0000_0800, 5'd7, 5'd0, 5'd0, 3'd0);
        chk("u800_err", out_err, 1);
        drain();

        send(3'd6, 32'h1234_5678, 5'd31, 5'd31, 5'd31, 3'd7);
        chk("rsv_instr", out_instruction, 0);
        chk("rsv_err", out_err, 1);
        chk("rsv_fmt", out_fmt, 6);
        drain();

        do_reset(1);
        send(3'd0, 32'd100, 5'd1, 5'd2, 5'd3, 3'd0);
        send(3'd1, -32'sd5, 5'd4, 5'd5, 5'd6, 3'd2);
        in_valid = 1'b1;
        in_fmt   = 3'd4;
        in_imm   = 32'd2048;
        @(negedge clk);
        chk("full_ready0", in_ready, 0);
        tick();
        @(negedge clk);
        chk("full_ready1", in_ready, 0);
        tick();
        out_ready = 1'b1;
        send(3'd4, 32'd2048, 5'd8, 5'd0, 5'd0, 3'd0);
        drain();
        chk("enc_cnt3", enc_count, 3);

        send(3'd0, 32'd1, 5'd1, 5'd1, 5'd1, 3'd1);
        send(3'd2, 32'd8, 5'd1, 5'd1, 5'd1, 3'd1);
        do_reset(1);
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_enc", enc_count, 0);
        chk("flush_err", err_count, 0);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;

        rand_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            logic [2:0] f;
            int r;
            r = int'($urandom_range(0, 15));
            f = (r < 14) ? 3'(r % 5) : 3'(5 + $urandom_range(0, 2));
            send(f, rand_imm(f), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_rdy = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
